// File: rtl/mix_sequencer_pkg.sv
// Shared types and constants for the VM2413 mix sequencer.
// Slot/stage types match the operator pipeline numbering.
package mix_sequencer_pkg;

    typedef logic [4:0] SLOT_TYPE;
    typedef logic [1:0] STAGE_TYPE;

    localparam SLOT_TYPE  SLOT_LAST  = 5'd17;
    localparam STAGE_TYPE STAGE_LAST = 2'd3;
    localparam int        MIX_W      = 14;

    typedef logic [MIX_W-1:0] mix_t;

endpackage

// File: rtl/mix_sample_fifo2.sv
// Two-entry sample FIFO between the sequencer and the audio path.
// A pop frees a slot in the same edge, so push+pop on full succeeds.
import mix_sequencer_pkg::*;

module mix_sample_fifo2 (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  mix_t data_i,
    input  logic pop_i,
    output mix_t head_o,
    output logic full_o,
    output logic empty_o,
    output logic drop_o
);

    mix_t       mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;
    assign head_o  = mem_q[rd_q];

    // Storage, pointers and occupancy update
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop)
                rd_q <= ~rd_q;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mix_sequencer.sv
// Clock-enable, stage and slot sequencer for the VM2413 pipeline.
// Captures one mixer sum per frame into a small output buffer.
import mix_sequencer_pkg::*;

module mix_sequencer #(
    parameter int CLK_DIV = 6,
    parameter int OVR_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             resync,
    input  logic             rhythm_req,
    input  mix_t             mixout,
    output logic             clkena,
    output SLOT_TYPE         slot,
    output STAGE_TYPE        stage,
    output logic             rhythm,
    output logic             frame_start,
    output mix_t             sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [OVR_W-1:0] overrun
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             clkena_q, clkena_d;
    SLOT_TYPE         slot_q, slot_d;
    STAGE_TYPE        stage_q, stage_d;
    logic             rhythm_q, rhythm_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             last_pulse;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;

    assign last_pulse = clkena_q && (slot_q == SLOT_LAST)
                        && (stage_q == STAGE_LAST);
    assign push = last_pulse && !resync;
    assign pop  = sample_ready;

    // Next-state for prescaler, counters, rhythm latch and overruns
    always_comb begin
        presc_d  = presc_q;
        clkena_d = 1'b0;
        slot_d   = slot_q;
        stage_d  = stage_q;
        rhythm_d = rhythm_q;
        ovr_d    = ovr_q;
        if (run) begin
            clkena_d = (presc_q == P_LAST);
            presc_d  = (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
        end
        if (clkena_q) begin
            stage_d = stage_q + 2'd1;
            if (stage_q == STAGE_LAST)
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 5'd1;
        end
        if (last_pulse)
            rhythm_d = rhythm_req;
        if (drop && (ovr_q != '1))
            ovr_d = ovr_q + 1'b1;
        if (resync) begin
            presc_d  = '0;
            clkena_d = 1'b0;
            slot_d   = '0;
            stage_d  = '0;
            rhythm_d = rhythm_req;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            clkena_q <= 1'b0;
            slot_q   <= '0;
            stage_q  <= '0;
            rhythm_q <= 1'b0;
            ovr_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            clkena_q <= clkena_d;
            slot_q   <= slot_d;
            stage_q  <= stage_d;
            rhythm_q <= rhythm_d;
            ovr_q    <= ovr_d;
        end
    end

    mix_sample_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (mixout),
        .pop_i   (pop),
        .head_o  (sample_data),
        .full_o  (full),
        .empty_o (empty),
        .drop_o  (drop)
    );

    assign clkena       = clkena_q;
    assign slot         = slot_q;
    assign stage        = stage_q;
    assign rhythm       = rhythm_q;
    assign overrun      = ovr_q;
    assign sample_valid = !empty;
    assign frame_start  = clkena_q && (slot_q == '0) && (stage_q == '0);

endmodule

// File: tb/tb_mix_sequencer.sv
// Randomized bench for mix_sequencer against a pulse-count model.
// Model tracks running cycles, pulse index in frame and a sample queue.
module tb_mix_sequencer;

    localparam int DIV = 6;
    localparam int OW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          resync;
    logic          rhythm_req;
    logic [13:0]   mixout;
    logic          clkena;
    logic [4:0]    slot;
    logic [1:0]    stage;
    logic          rhythm;
    logic          frame_start;
    logic [13:0]   sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic [OW-1:0] overrun;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // reference model state
    int          run_cnt = 0;
    int          pulses  = 0;
    bit          e_clkena = 0;
    bit          e_rhythm = 0;
    int          e_ovr = 0;
    logic [13:0] q[$];

    always #5 clk = ~clk;

    mix_sequencer #(.CLK_DIV(DIV), .OVR_W(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .resync       (resync),
        .rhythm_req   (rhythm_req),
        .mixout       (mixout),
        .clkena       (clkena),
        .slot         (slot),
        .stage        (stage),
        .rhythm       (rhythm),
        .frame_start  (frame_start),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    task automatic check_eq(string tag, int obs, int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Model: a pulse every DIV running cycles; 72 pulses per frame;
    // last pulse of a frame latches rhythm and offers mixout to the queue.
    always @(posedge clk) begin
        if (reset) begin
            run_cnt  = 0;
            pulses   = 0;
            e_clkena = 0;
            e_rhythm = 0;
            e_ovr    = 0;
            q.delete();
        end else begin
            bit adv;
            bit endp;
            adv  = e_clkena;
            endp = adv && (pulses == 71);
            if (q.size() > 0 && sample_ready)
                void'(q.pop_front());
            if (resync) begin
                run_cnt  = 0;
                pulses   = 0;
                e_clkena = 0;
                e_rhythm = rhythm_req;
            end else begin
                if (adv)
                    pulses = (pulses + 1) % 72;
                if (endp) begin
                    e_rhythm = rhythm_req;
                    if (q.size() < 2)
                        q.push_back(mixout);
                    else if (e_ovr < (1 << OW) - 1)
                        e_ovr++;
                end
                if (run) begin
                    run_cnt++;
                    e_clkena = (run_cnt % DIV == 0);
                end else begin
                    e_clkena = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("clkena", int'(clkena), int'(e_clkena));
            check_eq("slot", int'(slot), pulses / 4);
            check_eq("stage", int'(stage), pulses % 4);
            check_eq("rhythm", int'(rhythm), int'(e_rhythm));
            check_eq("frame_start", int'(frame_start),
                     int'(e_clkena && pulses == 0));
            check_eq("valid", int'(sample_valid), int'(q.size() > 0));
            check_eq("overrun", int'(overrun), e_ovr);
            if (q.size() > 0)
                check_eq("data", int'(sample_data), int'(q[0]));
        end
    end

    task automatic cycles(int n, bit rnd_run, bit rnd_rdy, int rs_odds);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mixout = 14'($urandom);
            if ($urandom_range(0, 199) == 0)
                rhythm_req = ~rhythm_req;
            if (rnd_run)
                run = ($urandom_range(0, 19) != 0);
            if (rnd_rdy && $urandom_range(0, 7) == 0)
                sample_ready = ~sample_ready;
            resync = (rs_odds > 0) && ($urandom_range(0, rs_odds - 1) == 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        run          = 1'b0;
        resync       = 1'b0;
        rhythm_req   = 1'b0;
        mixout       = '0;
        sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_clkena", int'(clkena), 0);
        check_eq("rst_slot", int'(slot), 0);
        check_eq("rst_stage", int'(stage), 0);
        check_eq("rst_rhythm", int'(rhythm), 0);
        check_eq("rst_fs", int'(frame_start), 0);
        check_eq("rst_data", int'(sample_data), 0);
        check_eq("rst_valid", int'(sample_valid), 0);
        check_eq("rst_ovr", int'(overrun), 0);
        reset        = 1'b0;
        run          = 1'b1;
        sample_ready = 1'b1;
        chk_en       = 1'b1;
        // steady running, consumer always ready
        cycles(3 * 72 * DIV, 0, 0, 0);
        // consumer stalled three frames: fill and overrun
        sample_ready = 1'b0;
        cycles(3 * 72 * DIV + 10, 0, 0, 0);
        sample_ready = 1'b1;
        cycles(60, 0, 0, 0);
        // fully random run/ready/resync
        cycles(20000, 1, 1, 1500);
        // frequent resyncs and long stalls to push overrun up
        sample_ready = 1'b0;
        cycles(8000, 1, 0, 3000);
        @(negedge clk);
        reset  = 1'b1;
        resync = 1'b0;
        run    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cycles(1500, 1, 1, 700);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
